// File: rtl/stream_arbiter_qos_pkg.sv
// Shared types and default widths for the QoS stream arbiter.
package stream_arbiter_qos_pkg;

  localparam int unsigned DefDataWidth   = 8;
  localparam int unsigned DefQosWidth    = 4;
  localparam int unsigned DefStreamCount = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/qos_rr_selector.sv
// Combinational winner selection: urgent (qos==0) lowest index first,
// otherwise highest qos with cyclic tie-break starting at rr_ptr.
module qos_rr_selector #(
  parameter int unsigned N  = 2,
  parameter int unsigned QW = 4,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0][QW-1:0] qos_i,
  input  logic [N-1:0]         valid_i,
  input  logic [IW-1:0]        rr_ptr_i,
  output logic [IW-1:0]        winner_o,
  output logic                 found_o
);

  logic          urg_found;
  logic [IW-1:0] urg_id;
  logic          best_found;
  logic [IW-1:0] best_id;
  logic [QW-1:0] best_qos;

  // Urgent scan: descending loop so the lowest urgent index is kept last.
  always_comb begin
    urg_found = 1'b0;
    urg_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_i[i] && (qos_i[i] == '0)) begin
        urg_found = 1'b1;
        urg_id    = IW'(i);
      end
    end
  end

  // Priority scan in cyclic order from rr_ptr; strict compare keeps the first tie.
  always_comb begin
    best_found = 1'b0;
    best_id    = '0;
    best_qos   = '0;
    for (int k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_i) + 32'(k)) % N;
      if (valid_i[idx] && (!best_found || (qos_i[idx] > best_qos))) begin
        best_found = 1'b1;
        best_id    = IW'(idx);
        best_qos   = qos_i[idx];
      end
    end
  end

  assign found_o  = urg_found | best_found;
  assign winner_o = urg_found ? urg_id : best_id;

endmodule

// File: rtl/stream_arbiter_qos.sv
// Packet-locked QoS arbiter: one grant per packet, 1-cycle arbitration in IDLE.
module stream_arbiter_qos
  import stream_arbiter_qos_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = DefDataWidth,
  parameter int unsigned T_QOS_WIDTH  = DefQosWidth,
  parameter int unsigned STREAM_COUNT = DefStreamCount,
  parameter int unsigned T_ID_WIDTH   = $clog2(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_QOS_WIDTH-1:0]                    m_qos_o,
  output logic [T_ID_WIDTH-1:0]                     m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  arb_state_e              state_q, state_d;
  logic [T_ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [T_QOS_WIDTH-1:0]  grant_qos_q, grant_qos_d;
  logic [T_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [T_ID_WIDTH-1:0]   sel_id;
  logic                    sel_found;
  logic                    last_hs;

  qos_rr_selector #(
    .N  (STREAM_COUNT),
    .QW (T_QOS_WIDTH),
    .IW (T_ID_WIDTH)
  ) u_sel (
    .qos_i    (s_qos_i),
    .valid_i  (s_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (sel_id),
    .found_o  (sel_found)
  );

  // State and grant registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      grant_qos_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      grant_qos_q <= grant_qos_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Datapath mux and handshake steering toward the granted stream.
  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_data_o  = s_data_i[grant_id_q];
    if (state_q == BUSY) begin
      m_valid_o             = s_valid_i[grant_id_q];
      m_last_o              = s_last_i[grant_id_q];
      s_ready_o[grant_id_q] = m_ready_i;
    end
  end

  assign last_hs = m_valid_o & m_ready_i & m_last_o;
  assign m_id_o  = grant_id_q;
  assign m_qos_o = grant_qos_q;

  // Next-state: grant in IDLE, release on last handshake and advance rr_ptr.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    grant_qos_d = grant_qos_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = BUSY;
          grant_id_d  = sel_id;
          grant_qos_d = s_qos_i[sel_id];
        end
      end
      BUSY: begin
        if (last_hs) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == T_ID_WIDTH'(STREAM_COUNT - 1)) ?
                     '0 : grant_id_q + T_ID_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
